alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable-high cycles before a button press is accepted.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 btn_up  input  1  raw, asynchronous "op select up" button.
REQ-005 btn_down  input  1  raw, asynchronous "op select down" button.
REQ-006 start  input  1  request one ALU operation; level-sampled.
REQ-007 a  input  4  operand A, two's complement.
REQ-008 b  input  4  operand B, two's complement.
REQ-009 op  output  3  current selected operation, registered.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse when result and flags are valid.
REQ-012 result  output  4  registered ALU result.
REQ-013 carry, zero, overflow  output  1 each  registered flags.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer; an event fires once per debounced rising edge, after DEBOUNCE_CYCLES stable-high cycles.
REQ-015 An up event SHALL increment op, saturating at 3'b111; a down event SHALL decrement op, saturating at 3'b000.
REQ-016 Up and down events in the same cycle SHALL leave op unchanged.
REQ-017 Button events while busy=1 SHALL be discarded.
REQ-018 FSM states SHALL be IDLE, LOAD, EXEC, DONE.
  - IDLE -> LOAD when start=1.
  - LOAD: latch a, b and op into internal registers -> EXEC.
  - EXEC: compute and register result and flags -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
REQ-019 busy SHALL be 1 in LOAD, EXEC and DONE, and 0 in IDLE.
REQ-020 start outside IDLE SHALL be ignored; a start held high SHALL yield one operation every 4 cycles.
REQ-021 Latency: with start sampled in cycle N, done SHALL be high in cycle N+3.
REQ-022 Op encoding: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-023 add: {carry,result} = a + b; overflow = (a[3]==b[3]) && (result[3]!=a[3]).
REQ-024 sub: {carry,result} = a + ~b + 1; overflow = (a[3]!=b[3]) && (result[3]!=a[3]).
REQ-025 Logic ops (010 to 101) SHALL force carry=0 and overflow=0.
REQ-026 Ops 110 and 111 SHALL return result = {3'b000, cond}, with carry=0 and overflow=0; 110 compares as signed.
REQ-027 zero SHALL equal (result==4'b0000) for every op.
REQ-028 result and flags SHALL hold their last value until the next EXEC.

Reset
REQ-029 rst=1 SHALL force on the next edge: state=IDLE, op=000, busy=0, done=0, result=0000, carry=0, zero=0, overflow=0; debouncers and synchronizers cleared.
REQ-030 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow.

Structure
REQ-031 Package alu_seq_pkg SHALL hold the op-encoding enum, the FSM state enum and OP_MAX=3'b111.
REQ-032 Sub-module alu_btn_debounce (synchronizer, debounce counter, edge pulse) SHALL be instantiated once per button.
REQ-033 The ALU datapath SHALL be a combinational function inside alu_op_sequencer.

Verification
REQ-034 Reset: assert rst for 2 cycles -> all outputs at the REQ-029 values.
REQ-035 add: op=000, a=0111, b=0001, start pulse -> 3 cycles later done=1, result=1000, carry=0, overflow=1, zero=0.
REQ-036 sub: op=001, a=0011, b=0011 -> result=0000, zero=1, carry=1, overflow=0. Signed less-than: op=110, a=1000, b=0001 -> result=0001.
REQ-037 Buttons (DEBOUNCE_CYCLES=4): 10 clean up presses -> op=111; 2-cycle glitch -> op unchanged; up and down together -> op unchanged; down at 000 -> op stays 000.
REQ-038 start held high for 12 cycles -> exactly 3 done pulses, busy low only in IDLE cycles; button press while busy -> op unchanged.
REQ-039 rst asserted in EXEC -> IDLE on the next cycle, result=0000, no done pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: op encoding, FSM states and ALU result bundle.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NOTA = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_EQ   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } seq_state_e;

  localparam logic [2:0] OP_MAX = 3'b111;
  localparam logic [2:0] OP_MIN = 3'b000;

  typedef struct packed {
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
  } alu_out_t;

endpackage

// File: rtl/alu_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-high counter, single-cycle pulse
// on each accepted press.
module alu_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Counter saturates at DEBOUNCE_CYCLES so a held button fires only once;
  // any low sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(DEBOUNCE_CYCLES)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) r_pulse <= 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_op_sequencer.sv
// Button-selected ALU operation sequencer: IDLE -> LOAD -> EXEC -> DONE per start request.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] op,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero,
  output logic       overflow
);

  seq_state_e r_state;
  seq_state_e w_next;
  logic [2:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  alu_op_e    r_op_lat;
  logic [3:0] r_result;
  logic       r_carry;
  logic       r_zero;
  logic       r_overflow;
  logic       w_up;
  logic       w_down;
  alu_out_t   w_alu;

  function automatic alu_out_t alu_eval(input alu_op_e f_op, input logic [3:0] f_a,
                                        input logic [3:0] f_b);
    alu_out_t   o;
    logic [4:0] sum;
    o   = '0;
    sum = '0;
    case (f_op)
      OP_ADD: begin
        sum        = {1'b0, f_a} + {1'b0, f_b};
        o.result   = sum[3:0];
        o.carry    = sum[4];
        o.overflow = (f_a[3] == f_b[3]) && (sum[3] != f_a[3]);
      end
      OP_SUB: begin
        sum        = {1'b0, f_a} + {1'b0, ~f_b} + 5'd1;
        o.result   = sum[3:0];
        o.carry    = sum[4];
        o.overflow = (f_a[3] != f_b[3]) && (sum[3] != f_a[3]);
      end
      OP_NOTA: o.result = ~f_a;
      OP_AND:  o.result = f_a & f_b;
      OP_OR:   o.result = f_a | f_b;
      OP_XOR:  o.result = f_a ^ f_b;
      OP_SLT:  o.result = {3'b000, $signed(f_a) < $signed(f_b)};
      OP_EQ:   o.result = {3'b000, f_a == f_b};
      default: o.result = '0;
    endcase
    o.zero = (o.result == 4'b0000);
    return o;
  endfunction

  alu_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_up),
    .o_pulse (w_up)
  );

  alu_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_down),
    .o_pulse (w_down)
  );

  assign w_alu = alu_eval(r_op_lat, r_a, r_b);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: w_next = ST_EXEC;
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Simultaneous up/down cancel; events arriving while busy are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= OP_MIN;
    end else if (!busy) begin
      if (w_up && !w_down && r_op != OP_MAX)
        r_op <= r_op + 3'd1;
      else if (w_down && !w_up && r_op != OP_MIN)
        r_op <= r_op - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op_lat   <= OP_ADD;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_a      <= a;
        r_b      <= b;
        r_op_lat <= alu_op_e'(r_op);
      end
      if (r_state == ST_EXEC) begin
        r_result   <= w_alu.result;
        r_carry    <= w_alu.carry;
        r_zero     <= w_alu.zero;
        r_overflow <= w_alu.overflow;
      end
    end
  end

  assign op       = r_op;
  assign result   = r_result;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int model_op;

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    btn_up   = up;
    btn_down = dn;
    tick(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(8);
  endtask

  task automatic press_up();
    press(1'b1, 1'b0, 10);
    if (model_op < 7) model_op++;
  endtask

  task automatic press_down();
    press(1'b0, 1'b1, 10);
    if (model_op > 0) model_op--;
  endtask

  task automatic set_op(input int target);
    while (model_op < target) press_up();
    while (model_op > target) press_down();
    check("set_op", op, target);
  endtask

  function automatic int sval(input int u);
    return (u >= 8) ? u - 16 : u;
  endfunction

  task automatic ref_alu(input int f_op, input int ua, input int ub,
                         output int r, output int c, output int z, output int v);
    int sa, sb, t;
    sa = sval(ua);
    sb = sval(ub);
    c = 0;
    v = 0;
    case (f_op)
      0: begin
        t = ua + ub;
        r = t % 16;
        c = (t > 15) ? 1 : 0;
        v = (sa + sb > 7 || sa + sb < -8) ? 1 : 0;
      end
      1: begin
        r = (ua - ub + 16) % 16;
        c = (ua >= ub) ? 1 : 0;
        v = (sa - sb > 7 || sa - sb < -8) ? 1 : 0;
      end
      2: r = 15 - ua;
      3: r = ua & ub;
      4: r = ua | ub;
      5: r = ua ^ ub;
      6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    z = (r == 0) ? 1 : 0;
  endtask

  task automatic run_op(input int ua, input int ub);
    int r, c, z, v;
    ref_alu(model_op, ua, ub, r, c, z, v);
    a     = 4'(ua);
    b     = 4'(ub);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_done", done, 0);
    tick(2);
    check("done_pulse", done, 1);
    check("result", result, r);
    check("carry", carry, c);
    check("zero", zero, z);
    check("overflow", overflow, v);
    tick();
    check("done_low", done, 0);
    check("idle_busy", busy, 0);
    a = 4'($urandom);
    b = 4'($urandom);
    tick(2);
    check("result_hold", result, r);
  endtask

  initial begin
    int n_done;
    int pre_op;
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    tick(2);
    check("rst_op", op, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    check("rst_overflow", overflow, 0);
    rst      = 1'b0;
    model_op = 0;
    tick(2);

    // directed ALU vectors
    set_op(0);
    run_op(4'b0111, 4'b0001);
    check("add_dir_result", result, 4'b1000);
    check("add_dir_ovf", overflow, 1);
    set_op(1);
    run_op(4'b0011, 4'b0011);
    check("sub_dir_zero", zero, 1);
    check("sub_dir_carry", carry, 1);
    set_op(6);
    run_op(4'b1000, 4'b0001);
    check("slt_dir_result", result, 4'b0001);

    // button behaviour
    set_op(0);
    for (int i = 0; i < 10; i++) press_up();
    check("up_saturate", op, 7);
    set_op(2);
    press(1'b1, 1'b0, 2);
    check("glitch_up", op, model_op);
    press(1'b1, 1'b1, 10);
    check("up_down_same", op, model_op);
    set_op(0);
    press_down();
    check("down_at_zero", op, 0);

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      set_op(int'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        press(1'b1, 1'b0, int'($urandom_range(1, 3)));
        check("rand_glitch", op, model_op);
      end
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    // start held high: one op every 4 cycles
    set_op(0);
    a      = 4'($urandom);
    b      = 4'($urandom);
    start  = 1'b1;
    n_done = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done) n_done++;
      check("held_done", done, (i % 4 == 3) ? 1 : 0);
      check("held_busy", busy, (i % 4 != 0) ? 1 : 0);
    end
    start = 1'b0;
    check("held_done_count", n_done, 3);
    tick(4);

    // presses at four phases of a held start: only the one landing in IDLE counts
    set_op(3);
    for (int k = 0; k < 4; k++) begin
      start = 1'b0;
      tick(8);
      start = 1'b1;
      tick(k);
      press(1'b1, 1'b0, 10);
    end
    start = 1'b0;
    tick(8);
    model_op = 4;
    check("busy_discard", op, 4);

    // reset during EXEC aborts the operation
    pre_op = model_op;
    a      = 4'b0101;
    b      = 4'b0011;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_abort_op", op, pre_op);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    model_op = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {carry, zero, overflow}, 3'b000);
    check("abort_op", op, 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
